// File: rtl/apb_master_pkg.sv
// Shared types for the APB initiator: FSM state encoding and packed command/response records.
package apb_master_pkg;

  // Widest data/address the packed records carry; the top may instantiate narrower buses.
  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_master_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  error;
  } apb_rsp_t;

  function automatic apb_rsp_t make_rsp(input logic [APB_DATA_W-1:0] rdata, input logic error);
    apb_rsp_t r;
    r.rdata = rdata;
    r.error = error;
    return r;
  endfunction

endpackage

// File: rtl/apb_master_timeout.sv
// ACCESS-phase wait counter for apb_master; only instantiated when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_timeout #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;

  // Flags the cycle whose wait state would make the count reach LIMIT, so the caller can abort on it.
  assign expired = en && (count_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB initiator: one command at a time over valid/ready, SETUP/ACCESS phases, response over valid/ready.
// Optional ACCESS-phase abort is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_master_state_e state_q, state_d;
  apb_cmd_t          cmd_q;
  apb_rsp_t          rsp_q;
  logic              cmd_hs;
  logic              timed_out;

  assign cmd_hs = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (PCLK),
    .rst    (PRESET),
    .clr    (state_q == SETUP),
    .en     ((state_q == ACCESS) && !PREADY),
    .expired(timed_out)
  );
`else
  // ACCESS waits for PREADY indefinitely; the limit has no effect in this build.
  assign timed_out = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    PSELx     = 1'b0;
    PENABLE   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = !PRESET;
        if (cmd_valid && !PRESET) state_d = SETUP;
      end
      SETUP: begin
        PSELx   = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        PSELx   = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || timed_out) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command fields stay registered after the transfer so PADDR/PWRITE hold their last values.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cmd_q <= '0;
      rsp_q <= '0;
    end else begin
      if (cmd_hs) begin
        cmd_q.write <= cmd_write;
        cmd_q.addr  <= APB_ADDR_W'(cmd_addr);
        cmd_q.wdata <= cmd_write ? APB_DATA_W'(cmd_wdata) : '0;
      end
      if (state_q == ACCESS) begin
        if (PREADY) begin
          rsp_q <= make_rsp(cmd_q.write ? '0 : APB_DATA_W'(PRDATA), PSLVERR);
        end else if (timed_out) begin
          rsp_q <= make_rsp('0, 1'b1);
        end
      end
    end
  end

  assign PWRITE    = cmd_q.write;
  assign PADDR     = cmd_q.addr[ADDR_WIDTH-1:0];
  assign PWDATA    = cmd_q.wdata[DATA_WIDTH-1:0];
  assign rsp_rdata = rsp_q.rdata[DATA_WIDTH-1:0];
  assign rsp_error = rsp_q.error;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: transaction-level model compared every cycle plus directed literal checks.
module tb_apb_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_write, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic          PSELx, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_master #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .PSELx    (PSELx),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  // Slave: PREADY rises after slv_wait enable cycles of the current transfer, or never while hung.
  int acc_cnt  = 0;
  int slv_wait = 0;
  bit slv_hang = 1'b0;
  always @(posedge PCLK) acc_cnt <= (PSELx === 1'b1 && PENABLE === 1'b1) ? acc_cnt + 1 : 0;
  assign PREADY = !slv_hang && (acc_cnt >= slv_wait);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: tracks one outstanding transfer and its pending response.
  bit            model_on = 1'b0;
  bit            m_busy = 1'b0, m_access = 1'b0, m_done = 1'b0, m_write = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  logic          m_error = 1'b0;
  int            m_waits = 0;

  always @(posedge PCLK) begin
    if (PRESET) begin
      model_on = 1'b1;
      m_busy = 1'b0; m_access = 1'b0; m_done = 1'b0; m_write = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_error = 1'b0;
    end else if (m_done) begin
      if (rsp_ready) m_done = 1'b0;
    end else if (m_busy) begin
      if (!m_access) begin
        m_access = 1'b1;
        m_waits  = 0;
      end else if (PREADY) begin
        m_busy  = 1'b0;
        m_done  = 1'b1;
        m_rdata = m_write ? '0 : PRDATA;
        m_error = PSLVERR;
      end else begin
        m_waits++;
`ifdef APB_MASTER_TIMEOUT_EN
        if (m_waits == TO) begin
          m_busy  = 1'b0;
          m_done  = 1'b1;
          m_rdata = '0;
          m_error = 1'b1;
        end
`endif
      end
    end else if (cmd_valid) begin
      m_busy   = 1'b1;
      m_access = 1'b0;
      m_write  = cmd_write;
      m_addr   = cmd_addr;
      m_wdata  = cmd_write ? cmd_wdata : '0;
    end
  end

  always @(negedge PCLK) begin
    if (model_on) begin
      chk("m_psel",      PSELx,     m_busy);
      chk("m_penable",   PENABLE,   m_busy && m_access);
      chk("m_pwrite",    PWRITE,    m_write);
      chk("m_paddr",     PADDR,     m_addr);
      chk("m_pwdata",    PWDATA,    m_wdata);
      chk("m_cmd_ready", cmd_ready, !m_busy && !m_done && !PRESET);
      chk("m_rsp_valid", rsp_valid, m_done);
      if (m_done) begin
        chk("m_rsp_rdata", rsp_rdata, m_rdata);
        chk("m_rsp_error", rsp_error, m_error);
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #2;
  endtask

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit hs = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int n = 0; n < 50 && !hs; n++) begin
      hs = (cmd_ready === 1'b1);
      tick();
    end
    cmd_valid = 1'b0; cmd_write = 1'bx; cmd_addr = 'x; cmd_wdata = 'x;
    chk("cmd_accepted", hs, 1'b1);
  endtask

  // Runs from SETUP until rsp_valid, counting ACCESS cycles and checking PADDR stays put.
  task automatic run_to_rsp(input string tag, input logic [AW-1:0] addr, output int acc);
    acc = 0;
    for (int n = 0; n < 100 && rsp_valid !== 1'b1; n++) begin
      if (PENABLE === 1'b1) begin
        acc++;
        chk({tag, "_paddr_stable"}, PADDR, addr);
      end
      tick();
    end
    chk({tag, "_rsp_seen"}, rsp_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int first, second;
    PRESET = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 'h44; cmd_wdata = 'h99;
    rsp_ready = 1'b1; PRDATA = '0; PSLVERR = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_psel",      PSELx,     1'b0);
      chk("rst_penable",   PENABLE,   1'b0);
      chk("rst_paddr",     PADDR,     '0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
    end
    PRESET = 1'b0; cmd_valid = 1'b0;
    #1;
    chk("cmd_ready_after_rst", cmd_ready, 1'b1);

    // Zero-wait write.
    slv_wait = 0;
    send(1'b1, 'h04, 'hA5);
    chk("wr_setup_psel",    PSELx,   1'b1);
    chk("wr_setup_penable", PENABLE, 1'b0);
    chk("wr_setup_paddr",   PADDR,   'h04);
    chk("wr_setup_pwdata",  PWDATA,  'hA5);
    chk("wr_setup_pwrite",  PWRITE,  1'b1);
    tick();
    chk("wr_access_penable", PENABLE, 1'b1);
    tick();
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_rsp_rdata", rsp_rdata, '0);
    chk("wr_rsp_error", rsp_error, 1'b0);
    chk("wr_rsp_psel",  PSELx,     1'b0);
    tick();
    chk("wr_idle_cmd_ready", cmd_ready, 1'b1);
    chk("wr_idle_paddr_kept", PADDR, 'h04);

    // Wait-state read.
    slv_wait = 3; PRDATA = 'h3C;
    send(1'b0, 'h08, 'hFFFF_FFFF);
    chk("rd_pwdata_zero", PWDATA, '0);
    run_to_rsp("rd", 'h08, acc);
    chk("rd_access_cycles", acc, 4);
    chk("rd_rsp_rdata", rsp_rdata, 'h3C);
    chk("rd_rsp_error", rsp_error, 1'b0);
    tick();

    // Slave error with response backpressure.
    slv_wait = 0; PSLVERR = 1'b1; rsp_ready = 1'b0; PRDATA = 'h21;
    send(1'b1, 'h10, 'h5A);
    run_to_rsp("err", 'h10, acc);
    chk("err_access_cycles", acc, 1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 'h0C; cmd_wdata = 'h11;
    for (int i = 0; i < 5; i++) begin
      chk("err_hold_valid",     rsp_valid, 1'b1);
      chk("err_hold_error",     rsp_error, 1'b1);
      chk("err_hold_rdata",     rsp_rdata, '0);
      chk("err_hold_cmd_ready", cmd_ready, 1'b0);
      tick();
    end
    rsp_ready = 1'b1; PSLVERR = 1'b0;
    tick();
    chk("err_idle_psel",      PSELx,     1'b0);
    chk("err_idle_cmd_ready", cmd_ready, 1'b1);
    tick();
    chk("next_setup_psel",    PSELx,   1'b1);
    chk("next_setup_penable", PENABLE, 1'b0);
    chk("next_setup_paddr",   PADDR,   'h0C);
    cmd_valid = 1'b0;
    run_to_rsp("next", 'h0C, acc);
    chk("next_rsp_rdata", rsp_rdata, 'h21);
    tick();

    // Reset during a wait state.
    slv_hang = 1'b1;
    send(1'b1, 'h14, 'h33);
    tick(); tick();
    chk("hang_penable", PENABLE, 1'b1);
    PRESET = 1'b1;
    tick();
    chk("midrst_psel",      PSELx,     1'b0);
    chk("midrst_penable",   PENABLE,   1'b0);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    PRESET = 1'b0; slv_hang = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_rsp", rsp_valid, 1'b0);
    end
    PRDATA = 'h77;
    send(1'b0, 'h18, '0);
    run_to_rsp("fresh", 'h18, acc);
    chk("fresh_rsp_rdata", rsp_rdata, 'h77);
    chk("fresh_rsp_error", rsp_error, 1'b0);
    tick();

`ifdef APB_MASTER_TIMEOUT_EN
    slv_hang = 1'b1; PRDATA = 'hEE;
    send(1'b0, 'h1C, '0);
    run_to_rsp("to", 'h1C, acc);
    chk("to_access_cycles", acc, TO);
    chk("to_rsp_error", rsp_error, 1'b1);
    chk("to_rsp_rdata", rsp_rdata, '0);
    tick();
    slv_hang = 1'b0; slv_wait = TO - 1; PSLVERR = 1'b1;
    send(1'b0, 'h20, '0);
    run_to_rsp("edge", 'h20, acc);
    chk("edge_access_cycles", acc, TO);
    chk("edge_rsp_error", rsp_error, 1'b1);
    chk("edge_rsp_rdata", rsp_rdata, 'hEE);
    tick();
    PSLVERR = 1'b0;
`else
    slv_wait = 20; PRDATA = 'hEE;
    send(1'b0, 'h1C, '0);
    run_to_rsp("long", 'h1C, acc);
    chk("long_access_cycles", acc, 21);
    chk("long_rsp_error", rsp_error, 1'b0);
    chk("long_rsp_rdata", rsp_rdata, 'hEE);
    tick();
`endif

    // Back-to-back throughput with commands always offered.
    slv_wait = 0; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 'h24; cmd_wdata = 'h1;
    first = -1; second = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (PSELx === 1'b1 && PENABLE === 1'b0) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_period", second - first, 4);
    for (int i = 0; i < 8; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
